// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction-fetch prefetch queue.
package fetch_pkg;

    localparam int unsigned FETCH_DEPTH   = 4;
    localparam int unsigned FETCH_XLEN    = 32;
    localparam int unsigned FETCH_DEPTH_W = $clog2(FETCH_DEPTH) + 1;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// Synchronous FIFO with flush; head is read combinationally from storage.
// Used for both the instruction queue and the in-flight PC FIFO.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   count_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] rd_q, rd_d;

    // Pointer update; flush wins over push/pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + CNT_W'(1);
            if (pop_i)  rd_d = rd_q + CNT_W'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write; contents need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_q[PTR_W-1:0]] <= push_data_i;
        end
    end

    assign empty_c = (wr_q == rd_q);
    assign count_c = wr_q - rd_q;
    assign head_c  = empty_c ? '0 : mem_q[rd_q[PTR_W-1:0]];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests to a
// variable-latency memory, buffers returned words with their PCs and hands them
// to IF/ID over valid/ready. Redirects flush wrong-path work; responses to
// requests issued before a redirect are counted off and dropped.
// Optional build macro FETCH_PERF_EN adds perf_starve/perf_flush counters.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned      DEPTH    = FETCH_DEPTH,
    parameter int unsigned      XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_ins
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_starve,
    output logic [31:0]     perf_flush
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] drop_calc;
    logic [CNT_W-1:0] q_count;
    logic [SUM_W-1:0] inflight_sum;
    logic             credit_ok;
    logic             req_fire;
    logic             q_empty;
    logic             q_pop;
    logic             rsp_take_c;
    logic             rsp_drop_c;
    fetch_entry_t     q_wdata;
    fetch_entry_t     q_head;
    logic [XLEN-1:0]  pc_head;
    logic [CNT_W-1:0] pc_cnt_unused;
    logic             pc_empty_unused;

    // Credit: queued entries plus in-flight requests never exceed DEPTH.
    assign inflight_sum   = SUM_W'(q_count) + SUM_W'(outstanding_q);
    assign credit_ok      = (inflight_sum < SUM_W'(DEPTH));
    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses still owed by memory, less one arriving this cycle, must be discarded.
    assign drop_calc = outstanding_q - CNT_W'(imem_rsp_valid);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // FSM next state: any redirect re-evaluates; DISCARD ends with the last dropped response.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = (drop_calc != '0) ? DISCARD : RUN;
        end else begin
            unique case (state_q)
                RUN:     state_d = RUN;
                DISCARD: if (imem_rsp_valid && drop_cnt_q == CNT_W'(1)) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // FSM outputs: keep or drop the response arriving this cycle.
    always_comb begin
        rsp_take_c = 1'b0;
        rsp_drop_c = 1'b0;
        if (imem_rsp_valid && !redirect_valid) begin
            rsp_take_c = (state_q == RUN);
            rsp_drop_c = (state_q == DISCARD);
        end
    end

    // Fetch PC, outstanding and drop counter next values.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            drop_cnt_d = drop_calc;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (rsp_drop_c && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // PCs of requests in flight, consumed in order by kept responses.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (req_fire),
        .push_data_i (fetch_pc_q),
        .pop_i       (rsp_take_c),
        .head_c      (pc_head),
        .empty_c     (pc_empty_unused),
        .count_c     (pc_cnt_unused)
    );

    assign q_wdata = {pc_head, imem_rsp_data};
    assign q_pop   = !q_empty && out_ready && !redirect_valid;

    // Instruction queue presented to IF/ID.
    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ins_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (rsp_take_c),
        .push_data_i (q_wdata),
        .pop_i       (q_pop),
        .head_c      (q_head),
        .empty_c     (q_empty),
        .count_c     (q_count)
    );

    assign out_valid = !q_empty;
    assign out_pc    = q_head.pc;
    assign out_ins   = q_head.ins;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_starve_q;
    logic [31:0] perf_flush_q;

    // Starvation and flush event counters (wrapping).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_starve_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (out_ready && q_empty) perf_starve_q <= perf_starve_q + 32'd1;
            if (redirect_valid)       perf_flush_q  <= perf_flush_q + 32'd1;
        end
    end

    assign perf_starve = perf_starve_q;
    assign perf_flush  = perf_flush_q;
`endif

endmodule
